// File: rtl/dm_access_ctrl_pkg.sv
// dm_access_pkg: shared op and state encodings for the data-memory access controller
package dm_access_pkg;
    typedef enum logic [2:0] {
        OP_W  = 3'b000,
        OP_H  = 3'b001,
        OP_HU = 3'b010,
        OP_B  = 3'b011,
        OP_BU = 3'b100
    } op_t;
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;
    localparam int WAIT_W = 4;
endpackage

// File: rtl/dm_access_ctrl_if.sv
// dm_access_ctrl_if: CPU, DMA and memory-port signals of the access controller
interface dm_access_ctrl_if
    import dm_access_pkg::*;
#(
    parameter int ADDR_W = 11
);
    logic              cpu_req;
    logic              cpu_we;
    op_t               cpu_op;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              cpu_adel;
    logic              cpu_ades;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [31:0]       dma_wdata;
    logic [31:0]       dma_rdata;
    logic              dma_ack;
    logic              busy;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_a;
    logic [31:0]       dm_wd;
    logic [31:0]       dm_rd;
    modport slave (
        input  cpu_req, cpu_we, cpu_op, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dm_rd,
        output cpu_rdata, cpu_stall, cpu_adel, cpu_ades,
        output dma_rdata, dma_ack, busy, dm_we, dm_be, dm_a, dm_wd
    );
    modport master (
        output cpu_req, cpu_we, cpu_op, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dm_rd,
        input  cpu_rdata, cpu_stall, cpu_adel, cpu_ades,
        input  dma_rdata, dma_ack, busy, dm_we, dm_be, dm_a, dm_wd
    );
endinterface

// File: rtl/dm_access_ctrl_lane_unit.sv
// dm_lane_unit: byte enables, load extraction/extension and misalignment for CPU ops
module dm_lane_unit
    import dm_access_pkg::*;
(
    input  op_t         i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rd,
    output logic [3:0]  o_be,
    output logic [31:0] o_rdata,
    output logic        o_mis
);
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    // select the addressed lane and derive enables, extended data and alignment
    always_comb begin
        w_half  = i_lane[1] ? i_rd[31:16] : i_rd[15:0];
        w_byte  = i_rd[{i_lane, 3'b000} +: 8];
        o_mis   = (i_op == OP_W && i_lane != 2'b00) || ((i_op == OP_H || i_op == OP_HU) && i_lane[0]);
        o_be    = (i_op == OP_W) ? 4'b1111 :
                  (i_op == OP_H || i_op == OP_HU) ? (i_lane[1] ? 4'b1100 : 4'b0011) :
                  4'b0001 << i_lane;
        o_rdata = (i_op == OP_W)  ? i_rd :
                  (i_op == OP_H)  ? {{16{w_half[15]}}, w_half} :
                  (i_op == OP_HU) ? {16'h0, w_half} :
                  (i_op == OP_B)  ? {{24{w_byte[7]}}, w_byte} :
                  (i_op == OP_BU) ? {24'h0, w_byte} : 32'h0;
    end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: shares the data-memory port between CPU and DMA and zero-fills it after reset
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int ADDR_W         = 11,
    parameter int MAX_WAIT       = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic             clk,
    input logic             reset,
    dm_access_ctrl_if.slave bus
);
    localparam logic [WAIT_W-1:0] W_MAX = WAIT_W'(MAX_WAIT);
    localparam state_t S_RST = CLEAR_ON_RESET ? CLEAR : RUN;
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [WAIT_W-1:0] r_wait;
    logic              r_ack;
    logic [31:0]       r_dma_rdata;
    logic              w_run, w_dma_win, w_cpu_win, w_cpu_acc, w_mis;
    logic [3:0]        w_be;
    logic [31:0]       w_rdata;

    dm_lane_unit u_lane (
        .i_op    (bus.cpu_op),
        .i_lane  (bus.cpu_addr[1:0]),
        .i_rd    (bus.dm_rd),
        .o_be    (w_be),
        .o_rdata (w_rdata),
        .o_mis   (w_mis)
    );

    assign bus.dma_ack   = r_ack;
    assign bus.dma_rdata = r_dma_rdata;
    assign bus.busy      = !w_run;

    // state, clear/wait counters and registered DMA response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_RST;
            r_clr_cnt   <= '0;
            r_wait      <= '0;
            r_ack       <= 1'b0;
            r_dma_rdata <= '0;
        end else begin
            r_state     <= w_next;
            r_clr_cnt   <= w_run ? r_clr_cnt : r_clr_cnt + 1'b1;
            r_wait      <= w_dma_win ? '0 : (w_run && bus.dma_req && r_wait != W_MAX) ? r_wait + 1'b1 : r_wait;
            r_ack       <= w_dma_win;
            r_dma_rdata <= w_dma_win ? bus.dm_rd : r_dma_rdata;
        end
    end

    // next state, arbitration and memory-port mux; a misaligned CPU access is granted but touches nothing
    always_comb begin
        w_run         = r_state == RUN;
        w_next        = (!w_run && r_clr_cnt == '1) ? RUN : r_state;
        w_dma_win     = w_run && bus.dma_req && (!bus.cpu_req || r_wait == W_MAX);
        w_cpu_win     = w_run && bus.cpu_req && !w_dma_win;
        w_cpu_acc     = w_cpu_win && !w_mis;
        bus.cpu_stall = bus.cpu_req && !w_cpu_win;
        bus.cpu_adel  = w_cpu_win && w_mis && !bus.cpu_we;
        bus.cpu_ades  = w_cpu_win && w_mis && bus.cpu_we;
        bus.cpu_rdata = (w_cpu_acc && !bus.cpu_we) ? w_rdata : 32'h0;
        bus.dm_we     = !w_run || (w_dma_win && bus.dma_we) || (w_cpu_acc && bus.cpu_we);
        bus.dm_be     = (!w_run || w_dma_win) ? 4'b1111 : w_cpu_acc ? w_be : 4'b0000;
        bus.dm_a      = !w_run ? r_clr_cnt : w_dma_win ? bus.dma_addr :
                        w_cpu_acc ? bus.cpu_addr[ADDR_W+1:2] : '0;
        bus.dm_wd     = w_dma_win ? bus.dma_wdata : (w_cpu_acc && bus.cpu_we) ? bus.cpu_wdata : 32'h0;
    end
endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Access controller in front of the word-organised data memory (2048 x 32, byte-enable writes, asynchronous read).
- Shares the single memory port between the CPU MEM stage and a secondary DMA/debug master.
- Converts CPU load/store ops into byte enables and extracted, extended load data.
- Sequences a hardware zero-fill of the whole memory after reset; no other agent clears memory.

Parameters:
ADDR_W, 11, word-address width (memory depth 2**ADDR_W words).
MAX_WAIT, 4, consecutive cycles the DMA may be denied before it is forced to win (range 1..15).
CLEAR_ON_RESET, 1, 1 = run the zero-fill sequence after reset; 0 = go straight to RUN.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
cpu_req  in  1  CPU MEM stage requests an access this cycle.
cpu_we  in  1  1 = store, 0 = load.
cpu_op  in  3  access type: OP_W, OP_H, OP_HU, OP_B, OP_BU (stores use W/H/B only).
cpu_addr  in  32  byte address; bits [ADDR_W+1:2] select the word, [1:0] select the lane.
cpu_wdata  in  32  store data, right-aligned.
cpu_rdata  out  32  extracted and extended load data, same cycle as grant.
cpu_stall  out  1  CPU request not served this cycle; the CPU must hold its request.
cpu_adel  out  1  misaligned load.
cpu_ades  out  1  misaligned store.
dma_req  in  1  DMA requests a full-word access; held until dma_ack.
dma_we  in  1  1 = write.
dma_addr  in  ADDR_W  word address.
dma_wdata  in  32  write data.
dma_rdata  out  32  registered read data, valid with dma_ack.
dma_ack  out  1  one-cycle pulse, cycle after the DMA access is performed.
busy  out  1  zero-fill in progress.
dm_we  out  1  memory write enable.
dm_be  out  4  memory byte enables.
dm_a  out  ADDR_W  memory word address.
dm_wd  out  32  memory write data.
dm_rd  in  32  memory read data (combinational from dm_a).

Behaviour:
- Reset (async): state <= CLEAR if CLEAR_ON_RESET else RUN. Clear counter <= 0, wait counter <= 0, dma_ack <= 0, dma_rdata <= 0.
- Outputs in CLEAR:
  - busy = 1, cpu_stall = cpu_req.
  - Each cycle: dm_we = 1, dm_be = 1111, dm_a = counter, dm_wd = 0; counter increments.
  - At counter = 2**ADDR_W-1, the write completes and the next state is RUN.
  - Total CLEAR length is exactly 2**ADDR_W cycles.
  - DMA requests are ignored; no dma_ack is issued.
- Reset asserted mid-CLEAR or mid-RUN: restart from the reset values; a pending dma_ack is dropped.
- RUN, cycle-by-cycle arbitration:
  - The DMA wins if dma_req and (not cpu_req, or wait counter = MAX_WAIT). Otherwise the CPU wins when cpu_req.
  - Wait counter: +1 each cycle dma_req is denied, saturating at MAX_WAIT; cleared when the DMA wins.
- CPU misalignment:
  - Misaligned when OP_W with addr[1:0] != 0, or OP_H/OP_HU with addr[0] = 1.
  - Raises cpu_adel (load) or cpu_ades (store) combinationally, only when cpu_req is set and the CPU is not stalled.
  - No memory write; cpu_rdata = 0. The access is still counted as granted (no stall).
- CPU granted store: dm_we = 1, dm_wd = cpu_wdata unmodified.
  - dm_be for W: 1111.
  - dm_be for H: 0011 (addr[1] = 0) or 1100 (addr[1] = 1).
  - dm_be for B: 0001 << addr[1:0].
  - The memory places the low byte/halfword into the enabled lane(s).
- CPU granted load: dm_we = 0; cpu_rdata is taken from dm_rd.
  - W: dm_rd unchanged.
  - H/HU: halfword at addr[1]*16, sign- or zero-extended.
  - B/BU: byte at addr[1:0]*8, sign- or zero-extended.
- CPU denied (DMA wins, or CLEAR): cpu_stall = 1, cpu_rdata = 0, no CPU side effects.
- DMA granted: dm_a = dma_addr, dm_be = 1111, dm_we = dma_we, dm_wd = dma_wdata.
  - Next cycle: dma_ack = 1 and dma_rdata <= dm_rd (read value; undefined-but-stable for writes).
  - The master must drop or change dma_req in the ack cycle. A request seen in the ack cycle is treated as a new request.
- Idle (no grant): dm_we = 0, dm_be = 0000, dm_a = 0, dm_wd = 0.
- Only one memory access per cycle; there is never a simultaneous CPU and DMA write.

Decomposition:
- Package dm_access_pkg: cpu_op encodings OP_W = 3'b000, OP_H = 001, OP_HU = 010, OP_B = 011, OP_BU = 100; state encodings CLEAR = 0, RUN = 1.
- Sub-module dm_lane_unit (combinational): op + addr[1:0] + dm_rd -> dm_be, cpu_rdata, misalignment flags.
- The top level holds the FSM, arbiter, wait counter, clear counter and DMA response registers.

Test Plan:
- Reset, CLEAR_ON_RESET = 1, ADDR_W = 4 -> busy high for exactly 16 cycles, dm_a = 0..15, dm_be = 1111, dm_wd = 0; cpu_req held during CLEAR gives cpu_stall = 1.
- RUN: sb addr 0x6, wdata 0x000000AB -> dm_be = 0100, dm_a = 1. Then lb 0x6 with dm_rd = 0x00AB0000 -> cpu_rdata = 0xFFFFFFAB; lbu -> 0x000000AB.
- sh addr 0x2 -> dm_be = 1100; lh addr 0x3 -> cpu_adel = 1, dm_we = 0, no stall. sw addr 0x5 -> cpu_ades = 1, dm_we = 0.
- cpu_req and dma_req both held, MAX_WAIT = 4 -> CPU granted 4 cycles, 5th cycle DMA granted with cpu_stall = 1, dma_ack next cycle, wait counter back to 0.
- DMA write 0x12345678 to word 3, then DMA read word 3 -> dma_ack pulses one cycle each, dma_rdata = 0x12345678.
- Reset asserted at clear counter = 7 -> dma_ack = 0 immediately; CLEAR restarts at dm_a = 0.
